blit_cmd_queue: RTL and testbench

BLIT_CMD_QUEUE -- requirements
Module: blit_cmd_queue

---
 rtl/blit_cmd_queue.sv | 163 ++++++++++++++++
 tb/tb_blit_cmd_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/blit_cmd_queue.sv
// Blitter command queue.
// The CPU fills three staging words through a small register window and then
// writes a command byte, which pushes one 104-bit command into a
// first-word-fall-through FIFO. The blitter command decoder reads the head
// entry directly and pops it with cmd_next unless the pipeline is stalled.
// Pushes into a full queue are dropped and recorded in a sticky overflow flag,
// which the CPU can read and clear.

module blit_cmd_queue #(
  parameter int DEPTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_write,
  input  logic          cpu_read,
  input  logic [2:0]    cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  input  logic          stall,
  output logic [103:0]  p0_cmd,
  output logic          p0_cmd_valid,
  input  logic          cmd_next,
  output logic          queue_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] ADDR_WORD0  = 3'd0;
  localparam logic [2:0] ADDR_WORD1  = 3'd1;
  localparam logic [2:0] ADDR_WORD2  = 3'd2;
  localparam logic [2:0] ADDR_PUSH   = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  // Staging words
  logic [31:0] word0_q, word0_d;
  logic [31:0] word1_q, word1_d;
  logic [31:0] word2_q, word2_d;

  // Queue bookkeeping
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  // Registered CPU read data
  logic [31:0] cpu_rdata_q, cpu_rdata_d;

  // Command storage; contents are meaningless outside the occupied window
  logic [103:0] cmd_mem [DEPTH];

  // Per-cycle control decisions
  logic         push_req;
  logic         pop;
  logic         full;
  logic         push_accept;
  logic         push_drop;
  logic         ovf_clear;
  logic [103:0] push_entry;
  logic [7:0]   count_ext;

  // Decode the CPU strobe and decoder handshake into push/pop/drop decisions
  always_comb begin
    push_req    = cpu_write && (cpu_addr == ADDR_PUSH);
    ovf_clear   = cpu_write && (cpu_addr == ADDR_STATUS) && cpu_wdata[31];
    full        = (count_q == CNT_W'(DEPTH));
    pop         = (count_q != '0) && cmd_next && !stall;
    push_accept = push_req && (!full || pop);
    push_drop   = push_req && full && !pop;
    push_entry  = {cpu_wdata[7:0], word2_q, word1_q, word0_q};
  end

  // Staging registers hold their value across pushes so only changed words need rewriting
  always_comb begin
    word0_d = word0_q;
    word1_d = word1_q;
    word2_d = word2_q;
    if (cpu_write) begin
      case (cpu_addr)
        ADDR_WORD0: word0_d = cpu_wdata;
        ADDR_WORD1: word1_d = cpu_wdata;
        ADDR_WORD2: word2_d = cpu_wdata;
        default:    ;
      endcase
    end
  end

  // Pointer, occupancy and sticky overflow next-state; a drop in the same cycle beats a clear
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_accept && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_accept) begin
      count_d = count_q - 1'b1;
    end
    if (ovf_clear) begin
      overflow_d = 1'b0;
    end
    if (push_drop) begin
      overflow_d = 1'b1;
    end
  end

  // CPU read mux, captured only on a read strobe so the last value is held otherwise
  always_comb begin
    count_ext   = 8'(count_q);
    cpu_rdata_d = cpu_rdata_q;
    if (cpu_read) begin
      case (cpu_addr)
        ADDR_WORD0:  cpu_rdata_d = word0_q;
        ADDR_WORD1:  cpu_rdata_d = word1_q;
        ADDR_WORD2:  cpu_rdata_d = word2_q;
        ADDR_STATUS: cpu_rdata_d = {overflow_q, 23'b0, count_ext};
        default:     cpu_rdata_d = 32'h0;
      endcase
    end
  end

  // State registers; reset wins over every simultaneous CPU or decoder action
  always_ff @(posedge clock) begin
    if (reset) begin
      word0_q     <= 32'h0;
      word1_q     <= 32'h0;
      word2_q     <= 32'h0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      cpu_rdata_q <= 32'h0;
    end else begin
      word0_q     <= word0_d;
      word1_q     <= word1_d;
      word2_q     <= word2_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // Storage write; no reset needed since occupancy alone decides what is valid
  always_ff @(posedge clock) begin
    if (!reset && push_accept) begin
      cmd_mem[wr_ptr_q] <= push_entry;
    end
  end

  assign p0_cmd       = cmd_mem[rd_ptr_q];
  assign p0_cmd_valid = (count_q != '0);
  assign queue_empty  = (count_q == '0);
  assign cpu_rdata    = cpu_rdata_q;

endmodule

// File: tb/tb_blit_cmd_queue.sv
// Self-checking bench for blit_cmd_queue with a scoreboard of expected commands.

module tb_blit_cmd_queue;

  localparam int DEPTH = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_write;
  logic          cpu_read;
  logic [2:0]    cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          stall;
  logic [103:0]  p0_cmd;
  logic          p0_cmd_valid;
  logic          cmd_next;
  logic          queue_empty;

  int checkCount = 0;
  int errorCount = 0;

  logic [103:0] sbq [$];
  logic [31:0]  stg0, stg1, stg2;
  logic         ovfModel;
  logic [31:0]  expRdata;

  blit_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_write    (cpu_write),
    .cpu_read     (cpu_read),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .stall        (stall),
    .p0_cmd       (p0_cmd),
    .p0_cmd_valid (p0_cmd_valid),
    .cmd_next     (cmd_next),
    .queue_empty  (queue_empty)
  );

  always #5 clock = ~clock;

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check visible state
  task automatic applyStimulus(input bit wr, input logic [2:0] addr, input logic [31:0] wdata,
                               input bit rd, input bit nxt, input bit stl, input bit rst);
    bit popped;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_read  = rd;
    cmd_next  = nxt;
    stall     = stl;
    reset     = rst;
    if (rst) begin
      sbq.delete();
      stg0 = 32'h0; stg1 = 32'h0; stg2 = 32'h0;
      ovfModel = 1'b0;
      expRdata = 32'h0;
    end else begin
      if (rd) begin
        case (addr)
          3'd0: expRdata = stg0;
          3'd1: expRdata = stg1;
          3'd2: expRdata = stg2;
          3'd4: expRdata = {ovfModel, 23'b0, 8'(sbq.size())};
          default: expRdata = 32'h0;
        endcase
      end
      popped = (sbq.size() > 0) && nxt && !stl;
      if (popped) begin
        checkOutput("pop_head", {24'h0, p0_cmd}, {24'h0, sbq[0]});
        void'(sbq.pop_front());
      end
      if (wr) begin
        case (addr)
          3'd0: stg0 = wdata;
          3'd1: stg1 = wdata;
          3'd2: stg2 = wdata;
          3'd3: begin
            if (sbq.size() < DEPTH) sbq.push_back({wdata[7:0], stg2, stg1, stg0});
            else ovfModel = 1'b1;
          end
          3'd4: if (wdata[31]) ovfModel = 1'b0;
          default: ;
        endcase
      end
    end
    @(posedge clock);
    #1;
    checkOutput("valid", {127'h0, p0_cmd_valid}, {127'h0, (sbq.size() != 0)});
    checkOutput("empty", {127'h0, queue_empty}, {127'h0, (sbq.size() == 0)});
    checkOutput("rdata", {96'h0, cpu_rdata}, {96'h0, expRdata});
    if (sbq.size() != 0)
      checkOutput("head", {24'h0, p0_cmd}, {24'h0, sbq[0]});
  endtask

  // Convenience: write staging word0 then push the command byte
  task automatic pushCmd(input logic [31:0] w0, input logic [7:0] cmd, input bit nxt);
    applyStimulus(1, 3'd0, w0, 0, nxt, 0, 0);
    applyStimulus(1, 3'd3, {24'h0, cmd}, 0, nxt, 0, 0);
  endtask

  initial begin
    cpu_write = 0; cpu_read = 0; cpu_addr = 0; cpu_wdata = 0;
    cmd_next = 0; stall = 0; reset = 1;

    // Reset state
    applyStimulus(0, 3'd0, 32'h0, 0, 0, 0, 1);
    applyStimulus(0, 3'd0, 32'h0, 0, 0, 0, 1);
    applyStimulus(0, 3'd4, 32'h0, 1, 0, 0, 0);
    checkOutput("reset_status", {96'h0, cpu_rdata}, 128'h0);

    // Field packing of a single command
    applyStimulus(1, 3'd0, 32'h0010_0020, 0, 0, 0, 0);
    applyStimulus(1, 3'd1, 32'h0005_0003, 0, 0, 0, 0);
    applyStimulus(1, 3'd2, 32'h0000_01FF, 0, 0, 0, 0);
    applyStimulus(1, 3'd3, 32'h0000_0003, 0, 0, 0, 0);
    checkOutput("packed_cmd", {24'h0, p0_cmd}, {24'h0, 104'h03_000001FF_00050003_00100020});
    checkOutput("packed_valid", {127'h0, p0_cmd_valid}, 128'h1);
    applyStimulus(0, 3'd1, 32'h0, 1, 1, 0, 0);
    checkOutput("stage_read", {96'h0, cpu_rdata}, {96'h0, 32'h0005_0003});

    // Fill to capacity then overflow
    for (int i = 0; i < DEPTH; i++) pushCmd(32'h100 + i, 8'(i + 1), 0);
    pushCmd(32'h1FF, 8'h99, 0);
    applyStimulus(0, 3'd4, 32'h0, 1, 0, 0, 0);
    checkOutput("full_ovf_status", {96'h0, cpu_rdata}, {96'h0, 32'h8000_0008});
    checkOutput("full_head", {120'h0, p0_cmd[103:96]}, 128'h1);

    // Clear overflow, then push and pop together while full
    applyStimulus(1, 3'd4, 32'h8000_0000, 0, 0, 0, 0);
    applyStimulus(1, 3'd3, 32'h0000_00AA, 0, 1, 0, 0);
    applyStimulus(0, 3'd4, 32'h0, 1, 0, 0, 0);
    checkOutput("full_pushpop_status", {96'h0, cpu_rdata}, {96'h0, 32'h0000_0008});

    // Writes to unused addresses change nothing
    applyStimulus(1, 3'd5, 32'hDEAD_BEEF, 0, 0, 0, 0);
    applyStimulus(1, 3'd6, 32'hDEAD_BEEF, 0, 0, 0, 0);
    applyStimulus(1, 3'd7, 32'h8000_0000, 0, 0, 0, 0);
    applyStimulus(0, 3'd5, 32'h0, 1, 0, 0, 0);
    applyStimulus(0, 3'd4, 32'h0, 1, 0, 0, 0);

    // Drain
    for (int i = 0; i < 3 * DEPTH && sbq.size() != 0; i++) applyStimulus(0, 3'd0, 32'h0, 0, 1, 0, 0);
    checkOutput("drain_empty", {127'h0, queue_empty}, 128'h1);

    // Stall blocks pops
    pushCmd(32'h2001, 8'h21, 0);
    pushCmd(32'h2002, 8'h22, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 3'd0, 32'h0, 0, 1, 1, 0);
    checkOutput("stall_head", {120'h0, p0_cmd[103:96]}, {120'h0, 8'h21});
    applyStimulus(0, 3'd0, 32'h0, 0, 1, 0, 0);
    applyStimulus(0, 3'd0, 32'h0, 0, 1, 0, 0);
    checkOutput("stall_empty", {127'h0, queue_empty}, 128'h1);

    // Random pop rate across pointer wrap
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 3'd0, 32'h3000 + i, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      applyStimulus(1, 3'd3, 32'h40 + i, 0, 1'($urandom_range(0, 1)), 0, 0);
    end
    for (int i = 0; i < 4 * DEPTH && sbq.size() != 0; i++) applyStimulus(0, 3'd0, 32'h0, 0, 1, 0, 0);
    checkOutput("random_drained", {127'h0, queue_empty}, 128'h1);

    // Reset with entries queued and a push in the same cycle
    for (int i = 0; i < 5; i++) pushCmd(32'h5000 + i, 8'(8'h50 + i), 0);
    applyStimulus(1, 3'd3, 32'h0000_0077, 0, 1, 0, 1);
    checkOutput("rst_valid", {127'h0, p0_cmd_valid}, 128'h0);
    applyStimulus(0, 3'd4, 32'h0, 1, 0, 0, 0);
    checkOutput("rst_status", {96'h0, cpu_rdata}, 128'h0);
    applyStimulus(0, 3'd0, 32'h0, 1, 0, 0, 0);
    checkOutput("rst_stage0", {96'h0, cpu_rdata}, 128'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
